// File: rtl/lock_pkg.sv
// Shared definitions for the electronic lock: state encoding, default
// parameters, counter widths and a BCD validity helper.
package lock_pkg;

  typedef enum logic [1:0] {
    ST_LOCKED  = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2
  } lock_state_e;

  localparam logic [15:0] DEFAULT_CODE_C     = 16'h1234;
  localparam int unsigned MAX_ATTEMPTS_C     = 3;
  localparam int unsigned LOCKOUT_CYCLES_C   = 30;
  localparam int unsigned OPEN_CYCLES_C      = 10;

  // Failure counter must hold MAX_ATTEMPTS up to 7.
  localparam int unsigned ATTEMPTS_W = 3;
  localparam int unsigned TIMER_W    = 8;

  // True when every nibble of a {bcd3,bcd2,bcd1,bcd0} word is a decimal digit.
  function automatic logic code_is_bcd(input logic [15:0] code);
    return (code[3:0]   <= 4'd9) && (code[7:4]   <= 4'd9) &&
           (code[11:8]  <= 4'd9) && (code[15:12] <= 4'd9);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a debounced button level: registers the level once
// and flags the cycle where the level is high and the registered copy is low.
module rise_detect (
  input  logic clk_slow,
  input  logic rst_n,
  input  logic i_level,
  output logic o_pulse
);

  logic r_level_q;

  always_ff @(posedge clk_slow or negedge rst_n) begin
    if (!rst_n) begin
      r_level_q <= 1'b0;
    end else begin
      // NOTE: clocked state uses <= so every flop samples pre-edge values;
      // a blocking = here would make ordering between blocks matter.
      r_level_q <= i_level;
    end
  end

  // Combinational so the controller acts on the very edge that first sees the press.
  assign o_pulse = i_level & ~r_level_q;

endmodule

// File: rtl/lock_controller.sv
// Code check and access-state stage of the electronic lock: compares entered
// BCD digits with the stored code, counts failures, times lockout and open.
module lock_controller
  import lock_pkg::*;
#(
  parameter logic [15:0] DEFAULT_CODE   = DEFAULT_CODE_C,
  parameter int unsigned MAX_ATTEMPTS   = MAX_ATTEMPTS_C,
  parameter int unsigned LOCKOUT_CYCLES = LOCKOUT_CYCLES_C,
  parameter int unsigned OPEN_CYCLES    = OPEN_CYCLES_C
) (
  input  logic                  clk_slow,
  input  logic                  rst_n,
  input  logic [3:0]            bcd0,
  input  logic [3:0]            bcd1,
  input  logic [3:0]            bcd2,
  input  logic [3:0]            bcd3,
  input  logic                  btn_submit,
  input  logic                  btn_set,
  output logic                  unlocked,
  output logic                  alarm,
  output logic [ATTEMPTS_W-1:0] attempts_left,
  output logic [TIMER_W-1:0]    time_left,
  output logic                  code_saved,
  output logic                  set_error
);

  localparam logic [ATTEMPTS_W-1:0] MAX_A     = ATTEMPTS_W'(MAX_ATTEMPTS);
  localparam logic [TIMER_W-1:0]    OPEN_T    = TIMER_W'(OPEN_CYCLES);
  localparam logic [TIMER_W-1:0]    LOCKOUT_T = TIMER_W'(LOCKOUT_CYCLES);

  logic w_submit_evt;
  logic w_set_evt;

  rise_detect u_submit_edge (
    .clk_slow (clk_slow),
    .rst_n    (rst_n),
    .i_level  (btn_submit),
    .o_pulse  (w_submit_evt)
  );

  rise_detect u_set_edge (
    .clk_slow (clk_slow),
    .rst_n    (rst_n),
    .i_level  (btn_set),
    .o_pulse  (w_set_evt)
  );

  logic [15:0] w_entered;
  logic        w_entered_ok;

  assign w_entered    = {bcd3, bcd2, bcd1, bcd0};
  assign w_entered_ok = code_is_bcd(w_entered);

  lock_state_e               r_state;
  logic [TIMER_W-1:0]        r_time;
  logic [ATTEMPTS_W-1:0]     r_fails;
  logic [15:0]               r_code;
  logic                      r_unlocked;
  logic                      r_alarm;
  logic [ATTEMPTS_W-1:0]     r_attempts_left;
  logic                      r_code_saved;
  logic                      r_set_error;

  lock_state_e               w_state_nxt;
  logic [TIMER_W-1:0]        w_time_nxt;
  logic [ATTEMPTS_W-1:0]     w_fails_nxt;
  logic [ATTEMPTS_W-1:0]     w_fails_inc;
  logic [15:0]               w_code_nxt;
  logic                      w_code_saved_nxt;
  logic                      w_set_error_nxt;

  // Saturating increment: the failure count never wraps past MAX_ATTEMPTS.
  assign w_fails_inc = (r_fails >= MAX_A) ? MAX_A : r_fails + 1'b1;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case below can leave a value unassigned and infer a latch.
    w_state_nxt      = r_state;
    w_time_nxt       = r_time;
    w_fails_nxt      = r_fails;
    w_code_nxt       = r_code;
    w_code_saved_nxt = 1'b0;
    w_set_error_nxt  = 1'b0;

    case (r_state)
      ST_LOCKED: begin
        w_time_nxt = '0;
        if (w_set_evt) begin
          w_set_error_nxt = 1'b1;
        end
        if (w_submit_evt) begin
          if (w_entered_ok && (w_entered == r_code)) begin
            w_state_nxt = ST_OPEN;
            w_time_nxt  = OPEN_T;
            w_fails_nxt = '0;
          end else begin
            w_fails_nxt = w_fails_inc;
            if (w_fails_inc >= MAX_A) begin
              w_state_nxt = ST_LOCKOUT;
              w_time_nxt  = LOCKOUT_T;
            end
          end
        end
      end

      // Submit relocks ahead of everything; expiry beats a same-edge set.
      ST_OPEN: begin
        if (w_submit_evt || (r_time <= TIMER_W'(1))) begin
          w_state_nxt = ST_LOCKED;
          w_time_nxt  = '0;
        end else begin
          w_time_nxt = r_time - 1'b1;
          if (w_set_evt) begin
            if (w_entered_ok) begin
              w_code_nxt       = w_entered;
              w_code_saved_nxt = 1'b1;
              w_time_nxt       = OPEN_T;
            end else begin
              w_set_error_nxt = 1'b1;
            end
          end
        end
      end

      ST_LOCKOUT: begin
        if (r_time <= TIMER_W'(1)) begin
          w_state_nxt = ST_LOCKED;
          w_time_nxt  = '0;
          w_fails_nxt = '0;
        end else begin
          w_time_nxt = r_time - 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_LOCKED;
        w_time_nxt  = '0;
        w_fails_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_slow or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_LOCKED;
      r_time          <= '0;
      r_fails         <= '0;
      // NOTE: the code register is a single word with a defined power-up
      // value, so it resets with everything else rather than being left to RAM.
      r_code          <= DEFAULT_CODE;
      r_unlocked      <= 1'b0;
      r_alarm         <= 1'b0;
      r_attempts_left <= MAX_A;
      r_code_saved    <= 1'b0;
      r_set_error     <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_time          <= w_time_nxt;
      r_fails         <= w_fails_nxt;
      r_code          <= w_code_nxt;
      r_unlocked      <= (w_state_nxt == ST_OPEN);
      r_alarm         <= (w_state_nxt == ST_LOCKOUT);
      r_attempts_left <= MAX_A - w_fails_nxt;
      r_code_saved    <= w_code_saved_nxt;
      r_set_error     <= w_set_error_nxt;
    end
  end

  assign unlocked      = r_unlocked;
  assign alarm         = r_alarm;
  assign attempts_left = r_attempts_left;
  assign time_left     = r_time;
  assign code_saved    = r_code_saved;
  assign set_error     = r_set_error;

endmodule

// File: tb/tb_lock_controller.sv
// Self-checking bench for lock_controller: directed scenarios with constant
// expectations, then randomized presses checked against a rule-level model.
module tb_lock_controller;

  localparam logic [15:0] DEF_CODE = 16'h1234;
  localparam int MAXA   = 3;
  localparam int LOCK_T = 30;
  localparam int OPEN_T = 10;

  logic       clk_slow = 1'b0;
  logic       rst_n    = 1'b0;
  logic [3:0] bcd0 = '0, bcd1 = '0, bcd2 = '0, bcd3 = '0;
  logic       btn_submit = 1'b0;
  logic       btn_set    = 1'b0;
  logic       unlocked, alarm, code_saved, set_error;
  logic [2:0] attempts_left;
  logic [7:0] time_left;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_slow = ~clk_slow;

  lock_controller dut (
    .clk_slow      (clk_slow),
    .rst_n         (rst_n),
    .bcd0          (bcd0),
    .bcd1          (bcd1),
    .bcd2          (bcd2),
    .bcd3          (bcd3),
    .btn_submit    (btn_submit),
    .btn_set       (btn_set),
    .unlocked      (unlocked),
    .alarm         (alarm),
    .attempts_left (attempts_left),
    .time_left     (time_left),
    .code_saved    (code_saved),
    .set_error     (set_error)
  );

  // Reference model: access mode, remaining dwell, failures, stored code.
  localparam int M_CLOSED = 0, M_ACCESS = 1, M_PENALTY = 2;
  int          m_mode, m_timer, m_fails;
  logic [15:0] m_code;
  bit          m_sub_prev, m_set_prev, m_saved, m_err;

  function automatic bit digits_ok(input logic [15:0] d);
    for (int i = 0; i < 4; i++) if (d[i*4 +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_mode = M_CLOSED; m_timer = 0; m_fails = 0; m_code = DEF_CODE;
    m_sub_prev = 0; m_set_prev = 0; m_saved = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit s, input bit t, input logic [15:0] d);
    bit se, te;
    se = s && !m_sub_prev;
    te = t && !m_set_prev;
    m_sub_prev = s; m_set_prev = t;
    m_saved = 0; m_err = 0;
    if (m_mode == M_CLOSED) begin
      if (te) m_err = 1;
      if (se) begin
        if (digits_ok(d) && d == m_code) begin
          m_mode = M_ACCESS; m_timer = OPEN_T; m_fails = 0;
        end else begin
          m_fails = (m_fails + 1 > MAXA) ? MAXA : m_fails + 1;
          if (m_fails == MAXA) begin m_mode = M_PENALTY; m_timer = LOCK_T; end
        end
      end
    end else if (m_mode == M_ACCESS) begin
      if (se || m_timer == 1) begin
        m_mode = M_CLOSED; m_timer = 0;
      end else begin
        m_timer = m_timer - 1;
        if (te && digits_ok(d)) begin
          m_code = d; m_saved = 1; m_timer = OPEN_T;
        end else if (te) begin
          m_err = 1;
        end
      end
    end else begin
      if (m_timer == 1) begin
        m_mode = M_CLOSED; m_timer = 0; m_fails = 0;
      end else begin
        m_timer = m_timer - 1;
      end
    end
  endtask

  function automatic logic [14:0] model_vec();
    return {m_mode == M_ACCESS, m_mode == M_PENALTY, 3'(MAXA - m_fails),
            8'(m_timer), m_saved, m_err};
  endfunction

  // One clk_slow cycle: drive on the falling edge, let the model see the
  // rising edge, and leave the caller 1 ns after it to sample outputs.
  task automatic step(input bit s, input bit t, input logic [15:0] d);
    @(negedge clk_slow);
    btn_submit = s; btn_set = t; {bcd3, bcd2, bcd1, bcd0} = d;
    @(posedge clk_slow);
    model_edge(s, t, d);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({unlocked, alarm, attempts_left, time_left, code_saved, set_error} !==
        {1'b0, 1'b0, 3'd3, 8'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset: u=%0b a=%0b att=%0d t=%0d cs=%0b se=%0b, want 0 0 3 0 0 0",
               unlocked, alarm, attempts_left, time_left, code_saved, set_error);
    end
    @(negedge clk_slow);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_open_timeout();
    step(1, 0, 16'h1234);
    n_cmp++;
    if (unlocked !== 1'b1 || time_left !== 8'd10 || attempts_left !== 3'd3) begin
      n_bad++;
      $display("FAIL open_entry: u=%0b t=%0d att=%0d, want 1 10 3", unlocked, time_left, attempts_left);
    end
    for (int i = 1; i <= 10; i++) begin
      step(0, 0, 16'h1234);
      n_cmp++;
      if (unlocked !== (i < 10) || time_left !== 8'(10 - i)) begin
        n_bad++;
        $display("FAIL open_dwell[%0d]: u=%0b t=%0d, want %0b %0d", i, unlocked, time_left, i < 10, 10 - i);
      end
    end
  endtask

  task automatic test_lockout();
    for (int k = 1; k <= 3; k++) begin
      step(1, 0, 16'h0000);
      n_cmp++;
      if (attempts_left !== 3'(3 - k) || alarm !== (k == 3) ||
          time_left !== ((k == 3) ? 8'd30 : 8'd0)) begin
        n_bad++;
        $display("FAIL fail_count[%0d]: att=%0d a=%0b t=%0d", k, attempts_left, alarm, time_left);
      end
      step(0, 0, 16'h0000);
    end
    step(1, 0, 16'h1234);
    n_cmp++;
    if (unlocked !== 1'b0 || alarm !== 1'b1 || attempts_left !== 3'd0 || time_left !== 8'd28) begin
      n_bad++;
      $display("FAIL lockout_submit: u=%0b a=%0b att=%0d t=%0d, want 0 1 0 28",
               unlocked, alarm, attempts_left, time_left);
    end
    step(0, 0, 16'h1234);
    for (int i = 1; i <= 27; i++) begin
      step(0, 0, 16'h0000);
      n_cmp++;
      if (alarm !== (i < 27) || time_left !== 8'(27 - i) ||
          attempts_left !== ((i < 27) ? 3'd0 : 3'd3)) begin
        n_bad++;
        $display("FAIL lockout_dwell[%0d]: a=%0b t=%0d att=%0d", i, alarm, time_left, attempts_left);
      end
    end
  endtask

  task automatic test_set_code();
    step(1, 0, 16'h1234);
    step(0, 0, 16'h1234);
    step(0, 0, 16'h9876);
    step(0, 1, 16'h9876);
    n_cmp++;
    if (code_saved !== 1'b1 || set_error !== 1'b0 || time_left !== 8'd10 || unlocked !== 1'b1) begin
      n_bad++;
      $display("FAIL set_store: cs=%0b se=%0b t=%0d u=%0b, want 1 0 10 1",
               code_saved, set_error, time_left, unlocked);
    end
    step(0, 1, 16'h9876);
    n_cmp++;
    if (code_saved !== 1'b0 || time_left !== 8'd9) begin
      n_bad++;
      $display("FAIL set_pulse_width: cs=%0b t=%0d, want 0 9", code_saved, time_left);
    end
    step(1, 0, 16'h9876);
    step(0, 0, 16'h9876);
    step(1, 0, 16'h1234);
    n_cmp++;
    if (unlocked !== 1'b0 || attempts_left !== 3'd2) begin
      n_bad++;
      $display("FAIL old_code_rejected: u=%0b att=%0d, want 0 2", unlocked, attempts_left);
    end
    step(0, 0, 16'h1234);
    step(1, 0, 16'h9876);
    n_cmp++;
    if (unlocked !== 1'b1 || attempts_left !== 3'd3) begin
      n_bad++;
      $display("FAIL new_code_opens: u=%0b att=%0d, want 1 3", unlocked, attempts_left);
    end
    step(0, 0, 16'h9876);
    step(1, 0, 16'h9876);
    step(0, 0, 16'h9876);
  endtask

  task automatic test_set_error();
    step(1, 0, 16'h9876);
    step(0, 0, 16'h9876);
    step(0, 1, 16'hA876);
    n_cmp++;
    if (set_error !== 1'b1 || code_saved !== 1'b0 || time_left !== 8'd8 || unlocked !== 1'b1) begin
      n_bad++;
      $display("FAIL set_bad_digit: se=%0b cs=%0b t=%0d u=%0b, want 1 0 8 1",
               set_error, code_saved, time_left, unlocked);
    end
    step(0, 0, 16'h9876);
    step(1, 0, 16'h9876);
    step(0, 0, 16'h9876);
    step(1, 0, 16'h9876);
    n_cmp++;
    if (unlocked !== 1'b1) begin
      n_bad++;
      $display("FAIL code_unchanged: u=%0b, want 1", unlocked);
    end
    step(0, 0, 16'h9876);
    step(1, 0, 16'h9876);
    step(0, 0, 16'h9876);
    step(0, 1, 16'h0000);
    n_cmp++;
    if (set_error !== 1'b1 || unlocked !== 1'b0 || attempts_left !== 3'd3) begin
      n_bad++;
      $display("FAIL set_while_locked: se=%0b u=%0b att=%0d, want 1 0 3", set_error, unlocked, attempts_left);
    end
    step(0, 0, 16'h0000);
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) step(1, 0, 16'h0000);
    n_cmp++;
    if (attempts_left !== 3'd2 || alarm !== 1'b0) begin
      n_bad++;
      $display("FAIL held_submit: att=%0d a=%0b, want 2 0", attempts_left, alarm);
    end
    step(0, 0, 16'h0000);
  endtask

  task automatic test_simultaneous();
    step(1, 0, 16'h9876);
    step(0, 0, 16'h9876);
    step(1, 1, 16'h1111);
    n_cmp++;
    if (unlocked !== 1'b0 || code_saved !== 1'b0 || set_error !== 1'b0) begin
      n_bad++;
      $display("FAIL submit_beats_set: u=%0b cs=%0b se=%0b, want 0 0 0", unlocked, code_saved, set_error);
    end
    step(0, 0, 16'h1111);
    step(1, 0, 16'h1111);
    n_cmp++;
    if (unlocked !== 1'b0 || attempts_left !== 3'd2) begin
      n_bad++;
      $display("FAIL dropped_set_not_stored: u=%0b att=%0d, want 0 2", unlocked, attempts_left);
    end
    step(0, 0, 16'h9876);
    step(1, 0, 16'h9876);
    step(0, 0, 16'h9876);
    step(1, 0, 16'h9876);
    step(0, 0, 16'h9876);
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 16'h0000);
      step(0, 0, 16'h0000);
    end
    for (int i = 0; i < 17; i++) step(0, 0, 16'h0000);
    n_cmp++;
    if (alarm !== 1'b1 || time_left !== 8'd12) begin
      n_bad++;
      $display("FAIL pre_reset_lockout: a=%0b t=%0d, want 1 12", alarm, time_left);
    end
    @(negedge clk_slow);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({unlocked, alarm, attempts_left, time_left, code_saved, set_error} !==
        {1'b0, 1'b0, 3'd3, 8'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL async_reset: u=%0b a=%0b att=%0d t=%0d cs=%0b se=%0b, want 0 0 3 0 0 0",
               unlocked, alarm, attempts_left, time_left, code_saved, set_error);
    end
    @(negedge clk_slow);
    rst_n = 1'b1;
    model_reset();
    step(1, 0, 16'h1234);
    n_cmp++;
    if (unlocked !== 1'b1) begin
      n_bad++;
      $display("FAIL code_reverted: u=%0b, want 1", unlocked);
    end
    step(0, 0, 16'h1234);
    step(1, 0, 16'h1234);
    step(0, 0, 16'h1234);
  endtask

  task automatic test_random();
    logic [15:0] d;
    bit s, t;
    int r;
    for (int n = 0; n < 800; n++) begin
      s = ($urandom_range(0, 3) == 0);
      t = ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, 9);
      if (r < 5) begin
        d = m_code;
      end else if (r < 8) begin
        d = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
             4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      end else begin
        d = m_code;
        d[$urandom_range(0, 3)*4 +: 4] = 4'($urandom_range(10, 15));
      end
      step(s, t, d);
      n_cmp++;
      if ({unlocked, alarm, attempts_left, time_left, code_saved, set_error} !== model_vec()) begin
        n_bad++;
        $display("FAIL random[%0d]: got u/a/att/t/cs/se=%h, want %h", n,
                 {unlocked, alarm, attempts_left, time_left, code_saved, set_error}, model_vec());
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_open_timeout();
    test_lockout();
    test_set_code();
    test_set_error();
    test_hold();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
